// File: rtl/pgr_i2s_stereo_pack_if.sv
// Stereo frame stream interface: FIFO head frame {left, right} with valid/ready.
interface pgr_i2s_stereo_pack_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [2*DATA_WIDTH-1:0] m_data;
  logic                    m_valid;
  logic                    m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/pgr_i2s_stereo_pack.sv
// Pairs left/right I2S channel words into stereo frames and buffers them in a
// first-word-fall-through FIFO with a valid/ready output stream.
// Optional macro PGR_I2S_PACK_MONO_EN adds mono_data = (L + R) >>> 1 of the FIFO head.
module pgr_i2s_stereo_pack #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          sck,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         data,
  input  logic                          l_vld,
  input  logic                          r_vld,
  pgr_i2s_stereo_pack_if.master         m,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          orphan,
`ifdef PGR_I2S_PACK_MONO_EN
  output logic [DATA_WIDTH-1:0]         mono_data,
`endif
  input  logic                          clr_flags
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {WAIT_L = 1'b0, HAVE_L = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_left;
  logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [LVL_W-1:0]        r_level;
  logic                    r_overflow;
  logic                    r_orphan;

  logic                    w_latch_left;
  logic                    w_push_req;
  logic                    w_orphan_evt;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_ovf_evt;
  logic [2*DATA_WIDTH-1:0] w_head;

  // Pairing FSM next-state and event decode; l_vld has priority over r_vld
  always_comb begin
    w_state_nxt  = r_state;
    w_latch_left = 1'b0;
    w_push_req   = 1'b0;
    w_orphan_evt = 1'b0;
    case (r_state)
      WAIT_L: begin
        if (l_vld) begin
          w_latch_left = 1'b1;
          w_state_nxt  = HAVE_L;
        end else if (r_vld) begin
          w_orphan_evt = 1'b1;
        end
      end
      HAVE_L: begin
        if (l_vld) begin
          w_latch_left = 1'b1;
          w_orphan_evt = 1'b1;
        end else if (r_vld) begin
          w_push_req  = 1'b1;
          w_state_nxt = WAIT_L;
        end
      end
      default: w_state_nxt = WAIT_L;
    endcase
  end

  // FIFO control: a pop frees the slot for a simultaneous push even when full
  always_comb begin
    w_empty   = (r_level == '0);
    w_full    = (r_level == LVL_FULL);
    w_pop     = !w_empty && m.m_ready;
    w_push    = w_push_req && (!w_full || w_pop);
    w_ovf_evt = w_push_req && w_full && !w_pop;
    w_head    = w_empty ? '0 : r_mem[r_rd_ptr];
  end

  // Pairing FSM state and left holding register
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_L;
      r_left  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_left) r_left <= data;
    end
  end

  // FIFO storage; contents are only visible through the level-qualified head
  always_ff @(posedge sck) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_left, data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // Sticky flags; a set event in the clearing cycle wins
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_orphan   <= 1'b0;
    end else begin
      r_overflow <= w_ovf_evt    || (r_overflow && !clr_flags);
      r_orphan   <= w_orphan_evt || (r_orphan   && !clr_flags);
    end
  end

  assign m.m_data   = w_head;
  assign m.m_valid  = !w_empty;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign orphan     = r_orphan;

`ifdef PGR_I2S_PACK_MONO_EN
  logic signed [DATA_WIDTH:0] w_mono_sum;

  // Sign-extended sum then arithmetic halving (floor); empty head yields 0
  always_comb begin
    w_mono_sum = $signed({w_head[2*DATA_WIDTH-1], w_head[2*DATA_WIDTH-1:DATA_WIDTH]})
               + $signed({w_head[DATA_WIDTH-1], w_head[DATA_WIDTH-1:0]});
    mono_data  = w_mono_sum[DATA_WIDTH:1];
  end
`endif

endmodule

// File: tb/tb_pgr_i2s_stereo_pack.sv
// Directed self-checking bench for pgr_i2s_stereo_pack (DATA_WIDTH=16, FIFO_DEPTH=8).
module tb_pgr_i2s_stereo_pack;

  logic        sck = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic        l_vld = 1'b0;
  logic        r_vld = 1'b0;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        orphan;
  logic        clr_flags = 1'b0;
`ifdef PGR_I2S_PACK_MONO_EN
  logic [15:0] mono_data;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pgr_i2s_stereo_pack_if #(.DATA_WIDTH(16)) u_if ();

  pgr_i2s_stereo_pack #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .sck        (sck),
    .rst_n      (rst_n),
    .data       (data),
    .l_vld      (l_vld),
    .r_vld      (r_vld),
    .m          (u_if.master),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .orphan     (orphan),
`ifdef PGR_I2S_PACK_MONO_EN
    .mono_data  (mono_data),
`endif
    .clr_flags  (clr_flags)
  );

  always #5 sck = ~sck;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  task automatic send_l(input logic [15:0] v);
    data = v; l_vld = 1'b1;
    tick();
    l_vld = 1'b0;
  endtask

  task automatic send_r(input logic [15:0] v);
    data = v; r_vld = 1'b1;
    tick();
    r_vld = 1'b0;
  endtask

  initial begin
    u_if.m_ready = 1'b0;
    #12;
    // reset values
    chk("rst_valid", 64'(u_if.m_valid), 64'd0);
    chk("rst_data", 64'(u_if.m_data), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_orphan", 64'(orphan), 64'd0);
    @(negedge sck);
    rst_n = 1'b1;
    tick();

    // basic stereo pairing, consumer always ready
    u_if.m_ready = 1'b1;
    send_l(16'h1234);
    chk("pair_lvl_after_l", 64'(fifo_level), 64'd0);
    send_r(16'hABCD);
    chk("pair_valid", 64'(u_if.m_valid), 64'd1);
    chk("pair_data", 64'(u_if.m_data), 64'h1234ABCD);
    chk("pair_level", 64'(fifo_level), 64'd1);
    tick();
    chk("pair_valid_drop", 64'(u_if.m_valid), 64'd0);
    chk("pair_level0", 64'(fifo_level), 64'd0);
    chk("pair_data0", 64'(u_if.m_data), 64'd0);

    // fill and overflow
    u_if.m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      send_l(16'(i));
      send_r(16'(i + 16'h100));
    end
    chk("fill_level", 64'(fifo_level), 64'd8);
    chk("fill_ovf", 64'(overflow), 64'd1);
    tick();
    chk("stall_hold", 64'(u_if.m_data), 64'h00010101);
    u_if.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", 64'(u_if.m_data), 64'({16'(i), 16'(i + 16'h100)}));
      tick();
    end
    chk("drain_empty", 64'(u_if.m_valid), 64'd0);
    chk("drain_level", 64'(fifo_level), 64'd0);
    u_if.m_ready = 1'b0;
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("ovf_clear", 64'(overflow), 64'd0);

    // orphans
    send_r(16'h0055);
    chk("orph_r_first", 64'(orphan), 64'd1);
    chk("orph_r_nopush", 64'(fifo_level), 64'd0);
    send_l(16'h0001);
    send_l(16'h0002);
    send_r(16'h0003);
    chk("orph_level", 64'(fifo_level), 64'd1);
    chk("orph_frame", 64'(u_if.m_data), 64'h00020003);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("orph_clear", 64'(orphan), 64'd0);
    u_if.m_ready = 1'b1; tick(); u_if.m_ready = 1'b0;
    chk("orph_drained", 64'(fifo_level), 64'd0);
    // set event coinciding with clear keeps the flag
    clr_flags = 1'b1;
    send_r(16'h0066);
    clr_flags = 1'b0;
    chk("orph_set_wins", 64'(orphan), 64'd1);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("orph_clear2", 64'(orphan), 64'd0);

    // full FIFO with push and pop together, across pointer wrap
    for (int i = 1; i <= 8; i++) begin
      send_l(16'(16'h10 + i));
      send_r(16'(16'h20 + i));
    end
    chk("pp_full", 64'(fifo_level), 64'd8);
    send_l(16'h0099);
    u_if.m_ready = 1'b1;
    send_r(16'h0098);
    chk("pp_level", 64'(fifo_level), 64'd8);
    chk("pp_no_ovf", 64'(overflow), 64'd0);
    for (int i = 2; i <= 8; i++) begin
      chk("pp_order", 64'(u_if.m_data), 64'({16'(16'h10 + i), 16'(16'h20 + i)}));
      tick();
    end
    chk("pp_last", 64'(u_if.m_data), 64'h00990098);
    tick();
    chk("pp_empty", 64'(fifo_level), 64'd0);
    u_if.m_ready = 1'b0;

    // reset mid-operation: 3 frames stored and a half pair pending
    for (int i = 1; i <= 3; i++) begin
      send_l(16'(i)); send_r(16'(i));
    end
    send_l(16'h0077);
    chk("mid_level3", 64'(fifo_level), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(u_if.m_valid), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    @(negedge sck);
    rst_n = 1'b1;
    tick();
    send_r(16'h0044);
    chk("mid_r_orphan", 64'(orphan), 64'd1);
    chk("mid_r_nopush", 64'(fifo_level), 64'd0);
    chk("mid_r_novalid", 64'(u_if.m_valid), 64'd0);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;

    // simultaneous l_vld and r_vld: right ignored, left latched
    data = 16'h0AAA; l_vld = 1'b1; r_vld = 1'b1;
    tick();
    l_vld = 1'b0; r_vld = 1'b0;
    chk("both_no_orphan", 64'(orphan), 64'd0);
    chk("both_no_push", 64'(fifo_level), 64'd0);
    send_r(16'h0BBB);
    chk("both_frame", 64'(u_if.m_data), 64'h0AAA0BBB);
    u_if.m_ready = 1'b1; tick(); u_if.m_ready = 1'b0;

`ifdef PGR_I2S_PACK_MONO_EN
    chk("mono_empty", 64'(mono_data), 64'd0);
    send_l(16'h7FFF); send_r(16'h7FFF);
    chk("mono_pos", 64'(mono_data), 64'h7FFF);
    u_if.m_ready = 1'b1; tick(); u_if.m_ready = 1'b0;
    send_l(16'h8000); send_r(16'hFFFF);
    chk("mono_neg", 64'(mono_data), 64'hBFFF);
    u_if.m_ready = 1'b1; tick(); u_if.m_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
